id_ex_stage_register: RTL and testbench
=======================================

Name: id_ex_stage_register

Overview:
- ID/EX pipeline stage. Sits directly downstream of the instruction-decode control unit and register file; consumes their outputs and presents them to the EX stage one cycle later.
- Contains load-use hazard detection. Inserts bubbles on hazards and on flush, and supports a global hold.
- Keeps a saturating count of load-use bubbles for performance debug.

Parameters:
- N_BITS, 32, datapath width of PC+4, register operands and immediate.
- CNT_BITS, 16, width of the bubble counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  squash the instruction entering EX (taken branch/jump).
- hold_i  in  1  freeze the whole stage (downstream memory busy).
- id_valid_i  in  1  ID holds a real instruction.
- id_RegDst_i, id_BranchEQ_i, id_BranchNE_i, id_MemRead_i, id_MemtoReg_i, id_MemWrite_i, id_ALUSrc_i, id_RegWrite_i  in  1 each  decoded control bits.
- id_ALUOp_i  in  3  decoded ALU operation class.
- id_pc4_i  in  N_BITS  PC+4 of the ID instruction.
- id_rd1_i, id_rd2_i  in  N_BITS  register file read data.
- id_imm_i  in  N_BITS  sign-extended immediate.
- id_rs_i, id_rt_i, id_rd_i, id_shamt_i  in  5 each  instruction fields.
- id_funct_i  in  6  function field.
- ex_* outputs  out  same widths  registered copies of every id_* input above (ex_valid_o, ex_RegDst_o, …, ex_funct_o).
- load_use_stall_o  out  1  stall request to PC and IF/ID register.
- bubble_count_o  out  CNT_BITS  saturating count of load-use bubbles.

Behaviour:
- Reset (async): all ex_* outputs = 0, ex_valid_o = 0, bubble_count_o = 0. load_use_stall_o = 0 because it derives from ex_valid_o.
- Hazard, combinational from registered state and current inputs:
  - hazard = ex_valid_o & ex_MemRead_o & (ex_rt_o != 0) & id_valid_i & ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i)).
  - load_use_stall_o = hazard & ~flush_i.
  - Zero-register destination never stalls.
- Per-edge update, priority highest first:
  1. flush_i = 1: load bubble. All ex_* = 0, ex_valid_o = 0. Counter unchanged. Flush overrides hold_i and hazard.
  2. hold_i = 1: every register, including the counter, keeps its value. load_use_stall_o still reflects hazard; upstream is frozen either way.
  3. hazard = 1: load bubble (all ex_* = 0, ex_valid_o = 0). bubble_count_o increments by 1, saturating at 2^CNT_BITS-1.
  4. Otherwise: all ex_* load the corresponding id_* inputs, and ex_valid_o <= id_valid_i.
- Latency: exactly 1 cycle ID→EX when no flush, hold or hazard.
- Bubble content: control bits all zero, so no register write and no memory access. Data fields are also zero for deterministic checking.
- A hazard resolves after exactly one bubble: the load then leaves EX, so ex_MemRead_o = 0 on the following cycle.
- Back-to-back loads each feeding the next instruction produce one bubble per load-use pair.
- Reset asserted mid-operation clears everything immediately, independent of clk. The first edge after reset deasserts behaves as case 4 (or 1/2).
- No internal state other than the registered fields and the counter; no FSM beyond this priority selection.

Test Plan:
- Reset then pass-through: reset=1 two cycles, release, present ADDI (RegWrite=1, ALUSrc=1, ALUOp=000, rs=8, rt=9, imm=0x5, valid=1) → next edge ex_RegWrite_o=1, ex_ALUSrc_o=1, ex_imm_o=0x00000005, ex_valid_o=1, load_use_stall_o=0.
- Load-use on rs: EX holds LW (MemRead=1, rt=10, valid=1), ID presents R-type rs=10 rt=11 → load_use_stall_o=1. Next edge: ex_valid_o=0, all controls 0, bubble_count_o=1. Following edge: the R-type loads, stall=0.
- Zero-register exemption: EX LW with rt=0, ID rs=0 → load_use_stall_o=0, no bubble, counter unchanged.
- Flush priority: hazard condition plus flush_i=1 and hold_i=1 on the same edge → bubble loaded, load_use_stall_o=0 during that cycle, bubble_count_o unchanged.
- Hold: load BEQ (BranchEQ=1), then hold_i=1 for 3 cycles while id_* inputs change → ex_BranchEQ_o=1 and all fields constant for 3 cycles. Release → new values load.
- Counter saturation and async reset: force 65536 hazards → bubble_count_o=0xFFFF and stays there. Assert reset between clock edges → all outputs 0 before the next edge.

Source files
------------

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold control
// and a saturating count of load-use bubbles.
module id_ex_stage_register #(
    parameter int unsigned N_BITS   = 32,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush_i,
    input  logic                hold_i,
    input  logic                id_valid_i,
    input  logic                id_RegDst_i,
    input  logic                id_BranchEQ_i,
    input  logic                id_BranchNE_i,
    input  logic                id_MemRead_i,
    input  logic                id_MemtoReg_i,
    input  logic                id_MemWrite_i,
    input  logic                id_ALUSrc_i,
    input  logic                id_RegWrite_i,
    input  logic [2:0]          id_ALUOp_i,
    input  logic [N_BITS-1:0]   id_pc4_i,
    input  logic [N_BITS-1:0]   id_rd1_i,
    input  logic [N_BITS-1:0]   id_rd2_i,
    input  logic [N_BITS-1:0]   id_imm_i,
    input  logic [4:0]          id_rs_i,
    input  logic [4:0]          id_rt_i,
    input  logic [4:0]          id_rd_i,
    input  logic [4:0]          id_shamt_i,
    input  logic [5:0]          id_funct_i,
    output logic                ex_valid_o,
    output logic                ex_RegDst_o,
    output logic                ex_BranchEQ_o,
    output logic                ex_BranchNE_o,
    output logic                ex_MemRead_o,
    output logic                ex_MemtoReg_o,
    output logic                ex_MemWrite_o,
    output logic                ex_ALUSrc_o,
    output logic                ex_RegWrite_o,
    output logic [2:0]          ex_ALUOp_o,
    output logic [N_BITS-1:0]   ex_pc4_o,
    output logic [N_BITS-1:0]   ex_rd1_o,
    output logic [N_BITS-1:0]   ex_rd2_o,
    output logic [N_BITS-1:0]   ex_imm_o,
    output logic [4:0]          ex_rs_o,
    output logic [4:0]          ex_rt_o,
    output logic [4:0]          ex_rd_o,
    output logic [4:0]          ex_shamt_o,
    output logic [5:0]          ex_funct_o,
    output logic                load_use_stall_o,
    output logic [CNT_BITS-1:0] bubble_count_o
);

    typedef struct packed {
        logic              valid;
        logic              regDst;
        logic              branchEq;
        logic              branchNe;
        logic              memRead;
        logic              memtoReg;
        logic              memWrite;
        logic              aluSrc;
        logic              regWrite;
        logic [2:0]        aluOp;
        logic [N_BITS-1:0] pc4;
        logic [N_BITS-1:0] rd1;
        logic [N_BITS-1:0] rd2;
        logic [N_BITS-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic [5:0]        funct;
    } stage_t;

    stage_t              idStage;
    stage_t              exStage;
    logic                hazard;
    logic [CNT_BITS-1:0] bubbleCount;

    // All per-instruction fields travel as one record so a bubble is a single '0 load.
    assign idStage = {id_valid_i, id_RegDst_i, id_BranchEQ_i, id_BranchNE_i, id_MemRead_i,
                      id_MemtoReg_i, id_MemWrite_i, id_ALUSrc_i, id_RegWrite_i, id_ALUOp_i,
                      id_pc4_i, id_rd1_i, id_rd2_i, id_imm_i, id_rs_i, id_rt_i, id_rd_i,
                      id_shamt_i, id_funct_i};

    always_comb begin
        hazard = exStage.valid && exStage.memRead && (exStage.rt != 5'd0) && id_valid_i &&
                 ((exStage.rt == id_rs_i) || (exStage.rt == id_rt_i));
    end

    assign load_use_stall_o = hazard & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exStage     <= '0;
            bubbleCount <= '0;
        end else if (flush_i) begin
            exStage <= '0;
        end else if (!hold_i) begin
            if (hazard) begin
                exStage <= '0;
                if (bubbleCount != '1) begin
                    bubbleCount <= bubbleCount + CNT_BITS'(1);
                end
            end else begin
                exStage <= idStage;
            end
        end
    end

    assign ex_valid_o     = exStage.valid;
    assign ex_RegDst_o    = exStage.regDst;
    assign ex_BranchEQ_o  = exStage.branchEq;
    assign ex_BranchNE_o  = exStage.branchNe;
    assign ex_MemRead_o   = exStage.memRead;
    assign ex_MemtoReg_o  = exStage.memtoReg;
    assign ex_MemWrite_o  = exStage.memWrite;
    assign ex_ALUSrc_o    = exStage.aluSrc;
    assign ex_RegWrite_o  = exStage.regWrite;
    assign ex_ALUOp_o     = exStage.aluOp;
    assign ex_pc4_o       = exStage.pc4;
    assign ex_rd1_o       = exStage.rd1;
    assign ex_rd2_o       = exStage.rd2;
    assign ex_imm_o       = exStage.imm;
    assign ex_rs_o        = exStage.rs;
    assign ex_rt_o        = exStage.rt;
    assign ex_rd_o        = exStage.rd;
    assign ex_shamt_o     = exStage.shamt;
    assign ex_funct_o     = exStage.funct;
    assign bubble_count_o = bubbleCount;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Bench for id_ex_stage_register: vector table plus hand sequences for
// counter saturation and asynchronous reset, checked through a scoreboard.
module tb_id_ex_stage_register;

    localparam int unsigned CNT = 8;
    localparam int          SAT = (1 << CNT) - 1;

    typedef struct packed {
        logic        valid;
        logic        regDst;
        logic        branchEq;
        logic        branchNe;
        logic        memRead;
        logic        memtoReg;
        logic        memWrite;
        logic        aluSrc;
        logic        regWrite;
        logic [2:0]  aluOp;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
    } stage_t;

    typedef struct {
        string  nm;
        logic   fl;
        logic   hd;
        stage_t id;
        logic   eS;
        stage_t eEx;
        int     eC;
    } vec_t;

    typedef struct {
        string  nm;
        stage_t ex;
        int     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic hold = 1'b0;
    stage_t idIn = '0;
    stage_t exOut;
    logic stall;
    logic [CNT-1:0] cnt;

    logic exValid, exRegDst, exBrEq, exBrNe, exMemRead, exMemtoReg, exMemWrite, exAluSrc, exRegWrite;
    logic [2:0] exAluOp;
    logic [31:0] exPc4, exRd1, exRd2, exImm;
    logic [4:0] exRs, exRt, exRd, exShamt;
    logic [5:0] exFunct;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t vt[$];

    always #5 clk = ~clk;

    id_ex_stage_register #(.N_BITS(32), .CNT_BITS(CNT)) dut (
        .clk(clk), .reset(reset), .flush_i(flush), .hold_i(hold),
        .id_valid_i(idIn.valid), .id_RegDst_i(idIn.regDst), .id_BranchEQ_i(idIn.branchEq),
        .id_BranchNE_i(idIn.branchNe), .id_MemRead_i(idIn.memRead), .id_MemtoReg_i(idIn.memtoReg),
        .id_MemWrite_i(idIn.memWrite), .id_ALUSrc_i(idIn.aluSrc), .id_RegWrite_i(idIn.regWrite),
        .id_ALUOp_i(idIn.aluOp), .id_pc4_i(idIn.pc4), .id_rd1_i(idIn.rd1), .id_rd2_i(idIn.rd2),
        .id_imm_i(idIn.imm), .id_rs_i(idIn.rs), .id_rt_i(idIn.rt), .id_rd_i(idIn.rd),
        .id_shamt_i(idIn.shamt), .id_funct_i(idIn.funct),
        .ex_valid_o(exValid), .ex_RegDst_o(exRegDst), .ex_BranchEQ_o(exBrEq), .ex_BranchNE_o(exBrNe),
        .ex_MemRead_o(exMemRead), .ex_MemtoReg_o(exMemtoReg), .ex_MemWrite_o(exMemWrite),
        .ex_ALUSrc_o(exAluSrc), .ex_RegWrite_o(exRegWrite), .ex_ALUOp_o(exAluOp),
        .ex_pc4_o(exPc4), .ex_rd1_o(exRd1), .ex_rd2_o(exRd2), .ex_imm_o(exImm),
        .ex_rs_o(exRs), .ex_rt_o(exRt), .ex_rd_o(exRd), .ex_shamt_o(exShamt), .ex_funct_o(exFunct),
        .load_use_stall_o(stall), .bubble_count_o(cnt)
    );

    assign exOut = {exValid, exRegDst, exBrEq, exBrNe, exMemRead, exMemtoReg, exMemWrite, exAluSrc,
                    exRegWrite, exAluOp, exPc4, exRd1, exRd2, exImm, exRs, exRt, exRd, exShamt, exFunct};

    function automatic stage_t mk(logic v, logic rDst, logic bEq, logic bNe, logic mRd, logic m2r,
                                  logic mWr, logic aSrc, logic rWr, logic [2:0] op, logic [31:0] pc4,
                                  logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm, logic [4:0] rs,
                                  logic [4:0] rt, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
        return {v, rDst, bEq, bNe, mRd, m2r, mWr, aSrc, rWr, op, pc4, rd1, rd2, imm, rs, rt, rd, sh, fn};
    endfunction

    function automatic vec_t vec(string nm, logic fl, logic hd, stage_t id, logic eS, stage_t eEx, int eC);
        vec_t r;
        r.nm = nm; r.fl = fl; r.hd = hd; r.id = id; r.eS = eS; r.eEx = eEx; r.eC = eC;
        return r;
    endfunction

    task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check the stall request, queue the post-edge expectation.
    task automatic step(string nm, logic fl, logic hd, stage_t id, logic eS, stage_t eEx, int eC);
        exp_t e;
        @(negedge clk);
        flush = fl; hold = hd; idIn = id;
        #1;
        chk({nm, ".stall"}, 256'(stall), 256'(eS));
        e.nm = nm; e.ex = eEx; e.cnt = eC;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({nm, ".scoreboard"}, 256'(0), 256'(1));
        end else begin
            e = sb.pop_front();
            chk({e.nm, ".ex"}, 256'(exOut), 256'(e.ex));
            chk({e.nm, ".cnt"}, 256'(cnt), 256'(e.cnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stage_t z, addi, lw, rtype, lw0, useZero, rtRt, beq, sll, lwB, useB, rtInv;
        int expCnt;

        z       = '0;
        addi    = mk(1,0,0,0,0,0,0,1,1,3'b000,32'h1004,32'h11,32'h22,32'h5,8,9,0,0,6'h00);
        lw      = mk(1,0,0,0,1,1,0,1,1,3'b000,32'h1008,32'h100,32'h0,32'h4,8,10,0,0,6'h00);
        rtype   = mk(1,1,0,0,0,0,0,0,1,3'b010,32'h100C,32'hAAAA,32'hBBBB,32'h1820,10,11,12,0,6'h20);
        lw0     = mk(1,0,0,0,1,1,0,1,1,3'b000,32'h1010,32'h3,32'h0,32'h8,3,0,0,0,6'h00);
        useZero = mk(1,1,0,0,0,0,0,0,1,3'b010,32'h1014,32'h0,32'h0,32'h0,0,0,14,0,6'h20);
        rtRt    = mk(1,1,0,0,0,0,0,0,1,3'b010,32'h1018,32'h5,32'h6,32'h0,5,10,15,0,6'h22);
        beq     = mk(1,0,1,0,0,0,0,0,0,3'b001,32'h0100,32'h7,32'h7,32'hFFFFFFFD,1,2,0,0,6'h00);
        sll     = mk(1,1,0,0,0,0,0,0,1,3'b010,32'h1024,32'h0,32'h9,32'h0,0,9,16,4,6'h00);
        lwB     = mk(1,0,0,0,1,1,0,1,1,3'b000,32'h101C,32'h200,32'h0,32'hC,10,13,0,0,6'h00);
        useB    = mk(1,0,0,1,0,0,0,0,0,3'b001,32'h1020,32'h1,32'h2,32'h10,4,13,0,0,6'h00);
        rtInv   = rtype;
        rtInv.valid = 1'b0;

        vt.push_back(vec("addi_pass",      0,0,addi,   0,addi,   0));
        vt.push_back(vec("lw_pass",        0,0,lw,     0,lw,     0));
        vt.push_back(vec("hazard_rs",      0,0,rtype,  1,z,      1));
        vt.push_back(vec("after_bubble",   0,0,rtype,  0,rtype,  1));
        vt.push_back(vec("lw_rt0",         0,0,lw0,    0,lw0,    1));
        vt.push_back(vec("zero_exempt",    0,0,useZero,0,useZero,1));
        vt.push_back(vec("lw_again",       0,0,lw,     0,lw,     1));
        vt.push_back(vec("flush_prio",     1,1,rtRt,   0,z,      1));
        vt.push_back(vec("beq_load",       0,0,beq,    0,beq,    1));
        vt.push_back(vec("hold1",          0,1,addi,   0,beq,    1));
        vt.push_back(vec("hold2",          0,1,lw,     0,beq,    1));
        vt.push_back(vec("hold3",          0,1,sll,    0,beq,    1));
        vt.push_back(vec("hold_release",   0,0,addi,   0,addi,   1));
        vt.push_back(vec("lw_pre_hold",    0,0,lw,     0,lw,     1));
        vt.push_back(vec("hold_hazard",    0,1,rtype,  1,lw,     1));
        vt.push_back(vec("hazard_rt_rel",  0,0,rtype,  1,z,      2));
        vt.push_back(vec("resolve",        0,0,rtype,  0,rtype,  2));
        vt.push_back(vec("b2b_lw1",        0,0,lw,     0,lw,     2));
        vt.push_back(vec("b2b_hz1",        0,0,lwB,    1,z,      3));
        vt.push_back(vec("b2b_lw2",        0,0,lwB,    0,lwB,    3));
        vt.push_back(vec("b2b_hz2",        0,0,useB,   1,z,      4));
        vt.push_back(vec("b2b_use",        0,0,useB,   0,useB,   4));
        vt.push_back(vec("lw_pre_inv",     0,0,lw,     0,lw,     4));
        vt.push_back(vec("invalid_id",     0,0,rtInv,  0,rtInv,  4));
        vt.push_back(vec("sll_pass",       0,0,sll,    0,sll,    4));
        vt.push_back(vec("flush_only",     1,0,addi,   0,z,      4));
        vt.push_back(vec("post_flush",     0,0,addi,   0,addi,   4));

        idIn = addi;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ex", 256'(exOut), 256'(z));
        chk("reset.cnt", 256'(cnt), 256'(0));
        chk("reset.stall", 256'(stall), 256'(0));
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            step(vt[i].nm, vt[i].fl, vt[i].hd, vt[i].id, vt[i].eS, vt[i].eEx, vt[i].eC);
        end

        expCnt = 4;
        for (int k = 0; k < SAT + 40; k++) begin
            step("sat_lw", 0, 0, lw, 0, lw, expCnt);
            expCnt = (expCnt < SAT) ? expCnt + 1 : SAT;
            step("sat_hz", 0, 0, rtype, 1, z, expCnt);
        end
        chk("sat_final", 256'(cnt), 256'(SAT));

        step("pre_reset_lw", 0, 0, lw, 0, lw, SAT);
        @(negedge clk);
        idIn = rtype;
        #1;
        chk("pre_reset.stall", 256'(stall), 256'(1));
        reset = 1'b1;
        #1;
        chk("async_reset.ex", 256'(exOut), 256'(z));
        chk("async_reset.cnt", 256'(cnt), 256'(0));
        chk("async_reset.stall", 256'(stall), 256'(0));
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("first_edge.ex", 256'(exOut), 256'(rtype));
        chk("first_edge.cnt", 256'(cnt), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
